// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, weight-state enum and saturating add for the systolic PE
package systolic_pkg;
  localparam int DEF_A_BITWIDTH = 8;
  localparam int DEF_W_BITWIDTH = 8;
  localparam int DEF_P_BITWIDTH = 24;
  localparam int DEF_LANES = 4;
  typedef enum logic {W_NONE = 1'b0, W_ACTIVE = 1'b1} w_state_e;
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int p);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (p - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/pe_lane_mul.sv
// pe_lane_mul: one signed A x W lane multiplier; ports a, w in, full-width signed product p out
module pe_lane_mul #(
  parameter int A_BITWIDTH = 8,
  parameter int W_BITWIDTH = 8
) (
  input  logic [A_BITWIDTH-1:0]                   a,
  input  logic [W_BITWIDTH-1:0]                   w,
  output logic signed [A_BITWIDTH+W_BITWIDTH-1:0] p
);
  assign p = (A_BITWIDTH+W_BITWIDTH)'(signed'(a)) * (A_BITWIDTH+W_BITWIDTH)'(signed'(w));
endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: double-buffered-weight multi-lane MAC PE; weight/activation forwarding, p_out = p_in + dot(a, w_active), optional saturation via SYSTOLIC_PE_SAT_EN
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int A_BITWIDTH = DEF_A_BITWIDTH,
  parameter int W_BITWIDTH = DEF_W_BITWIDTH,
  parameter int P_BITWIDTH = DEF_P_BITWIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_valid,
  input  logic [LANES*W_BITWIDTH-1:0]   w_in,
  input  logic                          w_swap,
  output logic [LANES*W_BITWIDTH-1:0]   w_out,
  output logic                          w_valid_out,
  output logic                          w_swap_out,
  input  logic                          a_valid,
  input  logic [LANES*A_BITWIDTH-1:0]   a_in,
  output logic [LANES*A_BITWIDTH-1:0]   a_out,
  output logic                          a_valid_out,
  input  logic [P_BITWIDTH-1:0]         p_in,
  output logic [P_BITWIDTH-1:0]         p_out,
  output logic                          p_valid_out,
  output logic                          ovf,
  output logic                          w_state
);
  localparam int AW = A_BITWIDTH + W_BITWIDTH;
  w_state_e state;
  logic [LANES*W_BITWIDTH-1:0] shadow, active, w_eff;
  logic shadow_full, swap_hit;
  logic signed [AW-1:0] prod [LANES];
  logic signed [P_BITWIDTH:0] lane_sum;
  logic [P_BITWIDTH-1:0] p_next;
  assign swap_hit = w_swap && shadow_full;
  assign w_eff = state == W_ACTIVE ? active : '0;
  assign w_state = state;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_mul #(.A_BITWIDTH(A_BITWIDTH), .W_BITWIDTH(W_BITWIDTH)) u_mul (
      .a(a_in[i*A_BITWIDTH +: A_BITWIDTH]),
      .w(w_eff[i*W_BITWIDTH +: W_BITWIDTH]),
      .p(prod[i])
    );
  end
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum += (P_BITWIDTH+1)'(prod[i]);
  end
`ifdef SYSTOLIC_PE_SAT_EN
  logic signed [63:0] sat_v;
  logic ovf_hit;
  assign sat_v = sat_add(64'(signed'(p_in)), 64'(lane_sum), P_BITWIDTH);
  assign ovf_hit = sat_v != 64'(signed'(p_in)) + 64'(lane_sum);
  assign p_next = sat_v[P_BITWIDTH-1:0];
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else if (a_valid && ovf_hit) ovf <= 1'b1;
`else
  assign p_next = P_BITWIDTH'(lane_sum + (P_BITWIDTH+1)'(signed'(p_in)));
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_NONE;
      shadow <= '0;
      active <= '0;
      shadow_full <= 1'b0;
      w_out <= '0;
      w_valid_out <= 1'b0;
      w_swap_out <= 1'b0;
      a_out <= '0;
      a_valid_out <= 1'b0;
      p_out <= '0;
      p_valid_out <= 1'b0;
    end else begin
      w_valid_out <= w_valid;
      w_swap_out <= w_swap;
      a_valid_out <= a_valid;
      p_valid_out <= a_valid;
      if (w_valid) begin
        shadow <= w_in;
        w_out <= w_in;
      end
      shadow_full <= w_valid ? 1'b1 : swap_hit ? 1'b0 : shadow_full;
      if (swap_hit) begin
        active <= shadow;
        state <= W_ACTIVE;
      end
      if (a_valid) begin
        a_out <= a_in;
        p_out <= p_next;
      end
    end
  end
endmodule
